wb_arbiter: RTL and testbench

Writeback arbiter feeding the single write port of the 32×32 register file. It merges single-cycle ALU results with variable-latency load returns into one registered write stream: `oWriteEn`, `oRdAddr` and `oWriteData`. It also keeps a load scoreboard, so the issue stage can stall on source or destination registers whose load data has not yet committed.

---
 rtl/wb_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Merges single-cycle ALU results and variable-latency load returns into one
//   registered register-file write stream. ALU results have strict priority.
//   Load returns wait in a small FIFO. A load scoreboard reports which
//   registers still have load data in flight.
//
// Ports
//   iClk, iRstN                    clock, asynchronous active-low reset
//   iAluValid/iAluRd/iAluData      ALU result, always accepted
//   iLdValid/iLdRd/iLdData         load return, accepted when oLdReady
//   oLdReady                       load FIFO not full
//   iIssueValid/iIssueRd           load issue, sets the pending bit of rd
//   iRs1Addr/iRs2Addr              scoreboard query addresses
//   oRs1Pending/oRs2Pending        pending status of the queried registers
//   oWriteEn/oRdAddr/oWriteData    registered register-file write port
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        iAluValid,
  input  logic [4:0]  iAluRd,
  input  logic [31:0] iAluData,
  input  logic        iLdValid,
  input  logic [4:0]  iLdRd,
  input  logic [31:0] iLdData,
  output logic        oLdReady,
  input  logic        iIssueValid,
  input  logic [4:0]  iIssueRd,
  input  logic [4:0]  iRs1Addr,
  input  logic [4:0]  iRs2Addr,
  output logic        oRs1Pending,
  output logic        oRs2Pending,
  output logic        oWriteEn,
  output logic [4:0]  oRdAddr,
  output logic [31:0] oWriteData
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          we_q, we_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   data_q, data_d;
  logic          from_fifo_q, from_fifo_d;
  logic [31:0]   pending_q, pending_d;

  logic          push;
  logic          pop;
  entry_t        head;

  assign oLdReady = (count_q != (AW+1)'(DEPTH));
  assign push     = iLdValid && oLdReady;
  // count_q only reflects entries written at earlier edges, so an entry
  // pushed this cycle cannot be popped until the next one.
  assign pop      = !iAluValid && (count_q != '0);
  assign head     = mem_q[rd_ptr_q];

  assign oRs1Pending = (iRs1Addr != 5'd0) && pending_q[iRs1Addr];
  assign oRs2Pending = (iRs2Addr != 5'd0) && pending_q[iRs2Addr];

  assign oWriteEn   = we_q;
  assign oRdAddr    = rd_q;
  assign oWriteData = data_q;

  always_comb begin
    we_d        = 1'b0;
    from_fifo_d = 1'b0;
    rd_d        = rd_q;
    data_d      = data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pending_d   = pending_q;

    if (iAluValid) begin
      rd_d   = iAluRd;
      data_d = iAluData;
      we_d   = (iAluRd != 5'd0);
    end else if (pop) begin
      rd_d        = head.rd;
      data_d      = head.data;
      we_d        = (head.rd != 5'd0);
      from_fifo_d = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);

    // The clear lands on the edge that commits the load data; a same-edge
    // issue to that register is applied afterwards so the set wins.
    if (we_q && from_fifo_q) pending_d[rd_q] = 1'b0;
    if (iIssueValid && (iIssueRd != 5'd0)) pending_d[iIssueRd] = 1'b1;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      we_q        <= 1'b0;
      rd_q        <= 5'd0;
      data_q      <= 32'd0;
      from_fifo_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pending_q   <= 32'd0;
    end else begin
      we_q        <= we_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      from_fifo_q <= from_fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge iClk) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: iLdRd, data: iLdData};
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
//   Directed bench for wb_arbiter: a vector table covering reset, ALU write,
//   load latency with scoreboard, contention and x0 handling, followed by
//   hand-written FIFO-full and mid-cycle reset sequences.
module tb_wb_arbiter;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        iAluValid;
  logic [4:0]  iAluRd;
  logic [31:0] iAluData;
  logic        iLdValid;
  logic [4:0]  iLdRd;
  logic [31:0] iLdData;
  logic        oLdReady;
  logic        iIssueValid;
  logic [4:0]  iIssueRd;
  logic [4:0]  iRs1Addr;
  logic [4:0]  iRs2Addr;
  logic        oRs1Pending;
  logic        oRs2Pending;
  logic        oWriteEn;
  logic [4:0]  oRdAddr;
  logic [31:0] oWriteData;

  int n_tests = 0;
  int n_fail  = 0;

  wb_arbiter #(.DEPTH(4)) dut (
    .iClk(iClk), .iRstN(iRstN),
    .iAluValid(iAluValid), .iAluRd(iAluRd), .iAluData(iAluData),
    .iLdValid(iLdValid), .iLdRd(iLdRd), .iLdData(iLdData),
    .oLdReady(oLdReady),
    .iIssueValid(iIssueValid), .iIssueRd(iIssueRd),
    .iRs1Addr(iRs1Addr), .iRs2Addr(iRs2Addr),
    .oRs1Pending(oRs1Pending), .oRs2Pending(oRs2Pending),
    .oWriteEn(oWriteEn), .oRdAddr(oRdAddr), .oWriteData(oWriteData)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) begin
    if (iRstN && iLdValid && !oLdReady)
      $display("[TB] protocol: load rd=%0d offered while oLdReady=0 (dropped)", iLdRd);
  end

  typedef struct {
    logic        alu_v;  logic [4:0] alu_rd; logic [31:0] alu_d;
    logic        ld_v;   logic [4:0] ld_rd;  logic [31:0] ld_d;
    logic        iss_v;  logic [4:0] iss_rd;
    logic [4:0]  rs1;    logic [4:0] rs2;
    logic        we;     logic [4:0] rd;     logic [31:0] wd;
    logic        rdy;    logic       p1;     logic        p2;
  } vec_t;

  function automatic vec_t mk(
      input logic av, input logic [4:0] ar, input logic [31:0] ad,
      input logic lv, input logic [4:0] lr, input logic [31:0] ld,
      input logic iv, input logic [4:0] ir,
      input logic [4:0] r1, input logic [4:0] r2,
      input logic we, input logic [4:0] rd, input logic [31:0] wd,
      input logic rdy, input logic p1, input logic p2);
    vec_t v;
    v.alu_v = av; v.alu_rd = ar; v.alu_d = ad;
    v.ld_v = lv;  v.ld_rd = lr;  v.ld_d = ld;
    v.iss_v = iv; v.iss_rd = ir;
    v.rs1 = r1;   v.rs2 = r2;
    v.we = we;    v.rd = rd;     v.wd = wd;
    v.rdy = rdy;  v.p1 = p1;     v.p2 = p2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic idle_inputs();
    iAluValid = 0; iAluRd = 0; iAluData = 0;
    iLdValid = 0;  iLdRd = 0;  iLdData = 0;
    iIssueValid = 0; iIssueRd = 0;
    iRs1Addr = 0; iRs2Addr = 0;
  endtask

  vec_t vecs[20];

  initial begin
    // Each row: inputs driven during a cycle, outputs expected in that cycle.
    vecs[0]  = mk(1,5,32'hDEADBEEF, 0,0,0,       0,0, 5,0, 0,0,0,            1,0,0);
    vecs[1]  = mk(0,0,0,            0,0,0,       0,0, 5,0, 1,5,32'hDEADBEEF, 1,0,0);
    vecs[2]  = mk(0,0,0,            0,0,0,       0,0, 0,0, 0,5,32'hDEADBEEF, 1,0,0);
    vecs[3]  = mk(0,0,0,            0,0,0,       1,7, 7,0, 0,5,32'hDEADBEEF, 1,0,0);
    vecs[4]  = mk(0,0,0,            0,0,0,       0,0, 7,0, 0,5,32'hDEADBEEF, 1,1,0);
    vecs[5]  = mk(0,0,0,            0,0,0,       0,0, 7,0, 0,5,32'hDEADBEEF, 1,1,0);
    vecs[6]  = mk(0,0,0,            1,7,32'h1234,0,0, 7,0, 0,5,32'hDEADBEEF, 1,1,0);
    vecs[7]  = mk(0,0,0,            0,0,0,       0,0, 7,0, 0,5,32'hDEADBEEF, 1,1,0);
    vecs[8]  = mk(0,0,0,            0,0,0,       0,0, 7,0, 1,7,32'h1234,     1,1,0);
    vecs[9]  = mk(0,0,0,            0,0,0,       0,0, 7,0, 0,7,32'h1234,     1,0,0);
    vecs[10] = mk(1,1,32'h11,       1,3,32'h33,  1,3, 7,3, 0,7,32'h1234,     1,0,0);
    vecs[11] = mk(1,2,32'h22,       0,0,0,       0,0, 0,3, 1,1,32'h11,       1,0,1);
    vecs[12] = mk(1,4,32'h44,       0,0,0,       0,0, 0,3, 1,2,32'h22,       1,0,1);
    vecs[13] = mk(0,0,0,            0,0,0,       0,0, 0,3, 1,4,32'h44,       1,0,1);
    vecs[14] = mk(0,0,0,            0,0,0,       0,0, 0,3, 1,3,32'h33,       1,0,1);
    vecs[15] = mk(0,0,0,            0,0,0,       0,0, 0,3, 0,3,32'h33,       1,0,0);
    vecs[16] = mk(1,0,32'hAA,       1,0,32'hBB,  1,0, 0,0, 0,3,32'h33,       1,0,0);
    vecs[17] = mk(0,0,0,            0,0,0,       0,0, 0,0, 0,0,32'hAA,       1,0,0);
    vecs[18] = mk(0,0,0,            0,0,0,       0,0, 0,0, 0,0,32'hBB,       1,0,0);
    vecs[19] = mk(0,0,0,            0,0,0,       0,0, 0,0, 0,0,32'hBB,       1,0,0);

    idle_inputs();
    iRstN = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    chk("rst.we",   oWriteEn,   0);
    chk("rst.rd",   oRdAddr,    0);
    chk("rst.data", oWriteData, 0);
    chk("rst.rdy",  oLdReady,   1);
    iRstN = 1'b1;

    for (int i = 0; i < 20; i++) begin
      iAluValid = vecs[i].alu_v; iAluRd = vecs[i].alu_rd; iAluData = vecs[i].alu_d;
      iLdValid = vecs[i].ld_v;   iLdRd = vecs[i].ld_rd;   iLdData = vecs[i].ld_d;
      iIssueValid = vecs[i].iss_v; iIssueRd = vecs[i].iss_rd;
      iRs1Addr = vecs[i].rs1;    iRs2Addr = vecs[i].rs2;
      #1;
      $display("[TB] vec %0d: we=%0b rd=%0d data=0x%0h rdy=%0b p1=%0b p2=%0b",
               i, oWriteEn, oRdAddr, oWriteData, oLdReady, oRs1Pending, oRs2Pending);
      chk($sformatf("v%0d.we", i),   oWriteEn,    vecs[i].we);
      chk($sformatf("v%0d.rd", i),   oRdAddr,     vecs[i].rd);
      chk($sformatf("v%0d.data", i), oWriteData,  vecs[i].wd);
      chk($sformatf("v%0d.rdy", i),  oLdReady,    vecs[i].rdy);
      chk($sformatf("v%0d.p1", i),   oRs1Pending, vecs[i].p1);
      chk($sformatf("v%0d.p2", i),   oRs2Pending, vecs[i].p2);
      step();
    end

    // FIFO full: continuous ALU stream starves the FIFO while loads arrive.
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      iAluValid = 1; iAluRd = 5'(10 + i); iAluData = 32'hA00 + i;
      iLdValid = (i < 5); iLdRd = 5'(20 + i); iLdData = 32'h100 + i;
      #1;
      $display("[TB] full %0d: we=%0b rd=%0d rdy=%0b", i, oWriteEn, oRdAddr, oLdReady);
      chk($sformatf("full%0d.rdy", i), oLdReady, (i < 4) ? 1 : 0);
      if (i >= 1) begin
        chk($sformatf("full%0d.we", i), oWriteEn, 1);
        chk($sformatf("full%0d.rd", i), oRdAddr, 10 + i - 1);
      end
      step();
    end
    idle_inputs();
    #1;
    chk("full.last_alu.rd", oRdAddr, 15);
    chk("full.last_alu.rdy", oLdReady, 0);
    step();
    for (int j = 0; j < 4; j++) begin
      #1;
      $display("[TB] drain %0d: we=%0b rd=%0d data=0x%0h rdy=%0b",
               j, oWriteEn, oRdAddr, oWriteData, oLdReady);
      chk($sformatf("drain%0d.we", j),   oWriteEn,   1);
      chk($sformatf("drain%0d.rd", j),   oRdAddr,    20 + j);
      chk($sformatf("drain%0d.data", j), oWriteData, 32'h100 + j);
      chk($sformatf("drain%0d.rdy", j),  oLdReady,   1);
      step();
    end
    #1;
    chk("drain.end.we", oWriteEn, 0);
    step();

    // Reset mid-operation with three loads queued and pending bits set.
    for (int k = 0; k < 3; k++) begin
      iAluValid = 1; iAluRd = 5'(16 + k); iAluData = 32'hC00 + k;
      iLdValid = 1;  iLdRd = 5'(11 + k);  iLdData = 32'h200 + k;
      iIssueValid = 1; iIssueRd = 5'(11 + k);
      step();
    end
    idle_inputs();
    iRs1Addr = 11; iRs2Addr = 13;
    #1;
    chk("pre_rst.p1", oRs1Pending, 1);
    chk("pre_rst.p2", oRs2Pending, 1);
    chk("pre_rst.we", oWriteEn, 1);
    chk("pre_rst.rd", oRdAddr, 18);
    #2;
    iRstN = 1'b0;
    #1;
    $display("[TB] async reset: we=%0b rd=%0d data=0x%0h rdy=%0b p1=%0b p2=%0b",
             oWriteEn, oRdAddr, oWriteData, oLdReady, oRs1Pending, oRs2Pending);
    chk("arst.we",   oWriteEn,    0);
    chk("arst.rd",   oRdAddr,     0);
    chk("arst.data", oWriteData,  0);
    chk("arst.rdy",  oLdReady,    1);
    chk("arst.p1",   oRs1Pending, 0);
    chk("arst.p2",   oRs2Pending, 0);
    @(posedge iClk);
    #3;
    iRstN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      chk($sformatf("post_rst%0d.we", k), oWriteEn, 0);
      chk($sformatf("post_rst%0d.p1", k), oRs1Pending, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
